// File: rtl/mem_arb.sv
// -----------------------------------------------------------------------------
// mem_arb -- two-requester memory arbiter (icache line fill vs. dcache MSHR)
//
// Purpose:
//   Shares a single request/acknowledge memory port between the icache
//   line-fill engine and the dcache MSHR. Only one transaction is in flight
//   at a time. When both requesters contend, they are served round-robin.
//   Every transaction passes through IDLE -> BUSY_x -> DONE, so grants are
//   always at least three cycles apart.
//
// Parameters:
//   TIMEOUT_CYC  mem_ack wait limit in cycles (1..255). Only used when the
//                timeout feature is compiled in.
//
// Optional feature (compile-time macro):
//   ARB_TIMEOUT_EN  When defined, a BUSY phase that waits TIMEOUT_CYC cycles
//                   without mem_ack is abandoned. The requester receives a
//                   done pulse with rdata=0 and err=1. When the macro is
//                   undefined, BUSY waits forever and err is tied to 0.
//
// Ports:
//   clk        in   single clock, all state changes on posedge
//   rst        in   synchronous active-high reset
//   ic_req     in   icache read request, held until ic_done
//   ic_addr    in   [31:0] icache read address
//   ic_done    out  one-cycle completion pulse to icache
//   ic_rdata   out  [31:0] icache read data, valid with ic_done
//   dc_req     in   dcache MSHR request, held until dc_done
//   dc_we      in   1 = eviction write, 0 = fill read
//   dc_addr    in   [31:0] dcache address
//   dc_wdata   in   [31:0] eviction write data
//   dc_done    out  one-cycle completion pulse to dcache
//   dc_rdata   out  [31:0] fill data, valid with dc_done (0 for writes)
//   mem_req    out  memory request, held until mem_ack
//   mem_we     out  memory write enable
//   mem_addr   out  [31:0] memory address
//   mem_wdata  out  [31:0] memory write data
//   mem_ack    in   one-cycle memory completion
//   mem_rdata  in   [31:0] memory read data, valid with mem_ack
//   err        out  timeout flag, valid with ic_done/dc_done
//
// FSM states:
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | no transaction; arbitration is evaluated here only
//   S_BUSY_IC  | icache request presented on the memory port, awaiting ack
//   S_BUSY_DC  | dcache request presented on the memory port, awaiting ack
//   S_DONE     | done pulse to the served requester; back to IDLE next edge
// -----------------------------------------------------------------------------
module mem_arb #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_rdata,

    input  logic        dc_req,
    input  logic        dc_we,
    input  logic [31:0] dc_addr,
    input  logic [31:0] dc_wdata,
    output logic        dc_done,
    output logic [31:0] dc_rdata,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IC = 2'd1;
    localparam logic [1:0] S_BUSY_DC = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    // A limit outside 1..255 does not fit the 8-bit wait counter.
    generate
        if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
            $error("mem_arb: TIMEOUT_CYC must be in 1..255");
        end
    endgenerate

    logic [1:0] state;
    logic       last_gnt;
    logic       gnt_ic;
    logic       gnt_dc;
    logic       busy;
    logic       timeout_hit;
    logic       finish;

    // Arbitration: single requester wins outright. On contention, the side
    // that was not granted last wins.
    always_comb begin
        gnt_ic = 1'b0;
        gnt_dc = 1'b0;
        if (state == S_IDLE) begin
            if (ic_req && dc_req) begin
                if (last_gnt == GNT_IC) begin
                    gnt_dc = 1'b1;
                end else begin
                    gnt_ic = 1'b1;
                end
            end else if (ic_req) begin
                gnt_ic = 1'b1;
            end else if (dc_req) begin
                gnt_dc = 1'b1;
            end
        end
    end

    assign busy   = (state == S_BUSY_IC) || (state == S_BUSY_DC);
    // An ack in the same cycle as the limit wins, because timeout_hit
    // requires !mem_ack.
    assign finish = busy && (mem_ack || timeout_hit);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

    logic [7:0] to_cnt;
    logic [7:0] to_cnt_nxt;
    logic       err_q;

    assign to_cnt_nxt  = to_cnt + 8'd1;
    assign timeout_hit = busy && !mem_ack && (to_cnt_nxt == TO_LIMIT);
    assign err         = err_q;

    // Counts BUSY cycles that end without mem_ack. It cannot wrap, because
    // reaching the limit always moves the FSM out of BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= 8'd0;
        end else if (gnt_ic || gnt_dc) begin
            to_cnt <= 8'd0;
        end else if (busy && !mem_ack) begin
            to_cnt <= to_cnt_nxt;
        end
    end

    // err is only ever high during the DONE cycle of a timed-out transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            last_gnt  <= GNT_IC;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            ic_done   <= 1'b0;
            ic_rdata  <= 32'd0;
            dc_done   <= 1'b0;
            dc_rdata  <= 32'd0;
        end else begin
            // Done pulses and read data are only non-zero in the DONE cycle.
            ic_done  <= 1'b0;
            ic_rdata <= 32'd0;
            dc_done  <= 1'b0;
            dc_rdata <= 32'd0;

            case (state)
                S_IDLE: begin
                    if (gnt_ic) begin
                        state     <= S_BUSY_IC;
                        last_gnt  <= GNT_IC;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= ic_addr;
                        mem_wdata <= 32'd0;
                    end else if (gnt_dc) begin
                        state     <= S_BUSY_DC;
                        last_gnt  <= GNT_DC;
                        mem_req   <= 1'b1;
                        mem_we    <= dc_we;
                        mem_addr  <= dc_addr;
                        mem_wdata <= dc_we ? dc_wdata : 32'd0;
                    end
                end

                S_BUSY_IC, S_BUSY_DC: begin
                    if (finish) begin
                        state   <= S_DONE;
                        mem_req <= 1'b0;
                        if (state == S_BUSY_IC) begin
                            ic_done  <= 1'b1;
                            ic_rdata <= mem_ack ? mem_rdata : 32'd0;
                        end else begin
                            dc_done  <= 1'b1;
                            // Eviction writes return no data.
                            dc_rdata <= (mem_ack && !mem_we) ? mem_rdata : 32'd0;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
module tb_mem_arb;

`ifdef ARB_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_done;
    logic [31:0] ic_rdata;
    logic        dc_req;
    logic        dc_we;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_done;
    logic [31:0] dc_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    mem_arb #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_rdata(dc_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        dc;
        logic [31:0] rdata;
        logic        err;
    } done_exp_t;

    // Transaction-level view of the arbiter: is the port free, serving a
    // memory access, or handing back a response.
    typedef enum int { PH_FREE, PH_MEM, PH_RESP } phase_t;

    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];

    int     errors = 0;
    int     checks = 0;
    logic   exp_mem_req = 1'b0;
    logic   chk_reset = 1'b0;

    phase_t ph = PH_FREE;
    logic   m_last_dc = 1'b0;
    logic   m_owner_dc = 1'b0;
    logic   m_we = 1'b0;
    int     m_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applied once per cycle at the negedge, using the inputs about to be
    // sampled at the next posedge.
    task automatic model_step();
        logic      pick_dc;
        mem_exp_t  me;
        done_exp_t de;
        if (rst) begin
            ph          = PH_FREE;
            m_last_dc   = 1'b0;
            exp_mem_req = 1'b0;
            chk_reset   = 1'b1;
            m_wait      = 0;
            return;
        end
        case (ph)
            PH_FREE: begin
                if (ic_req || dc_req) begin
                    pick_dc  = (ic_req && dc_req) ? !m_last_dc : dc_req;
                    me.we    = pick_dc ? dc_we : 1'b0;
                    me.addr  = pick_dc ? dc_addr : ic_addr;
                    me.wdata = (pick_dc && dc_we) ? dc_wdata : 32'h0;
                    mem_q.push_back(me);
                    m_last_dc   = pick_dc;
                    m_owner_dc  = pick_dc;
                    m_we        = me.we;
                    m_wait      = 0;
                    exp_mem_req = 1'b1;
                    ph          = PH_MEM;
                end
            end
            PH_MEM: begin
                if (mem_ack) begin
                    de.dc    = m_owner_dc;
                    de.rdata = m_we ? 32'h0 : mem_rdata;
                    de.err   = 1'b0;
                    done_q.push_back(de);
                    exp_mem_req = 1'b0;
                    ph          = PH_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        de.dc    = m_owner_dc;
                        de.rdata = 32'h0;
                        de.err   = 1'b1;
                        done_q.push_back(de);
                        exp_mem_req = 1'b0;
                        ph          = PH_RESP;
                    end
                end
`endif
            end
            default: ph = PH_FREE;
        endcase
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk);
    endtask

    // Drives an ack after lat idle BUSY cycles; returns in the cycle after the ack.
    task automatic mem_resp(input int lat, input logic [31:0] data);
        mem_ack = 1'b0;
        repeat (lat) cyc();
        mem_ack   = 1'b1;
        mem_rdata = data;
        cyc();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
    endtask

    // Monitor: samples 1 ns after each posedge and compares against the queues.
    initial begin
        mem_exp_t  e;
        mem_exp_t  cur;
        done_exp_t d;
        logic        eic, edc, eerr;
        logic [31:0] eir, edr;
        cur = '{1'b0, 32'h0, 32'h0};
        forever begin
            @(posedge clk);
            #1;
            if (chk_reset) begin
                check("rst_mem_we", mem_we, 0);
                check("rst_mem_addr", mem_addr, 0);
                check("rst_mem_wdata", mem_wdata, 0);
                chk_reset = 1'b0;
            end
            check("mem_req", mem_req, exp_mem_req);
            if (mem_q.size() > 0) begin
                e = mem_q.pop_front();
                check("grant_we", mem_we, e.we);
                check("grant_addr", mem_addr, e.addr);
                check("grant_wdata", mem_wdata, e.wdata);
                cur = e;
            end else if (exp_mem_req) begin
                check("hold_addr", mem_addr, cur.addr);
                check("hold_we", mem_we, cur.we);
                check("hold_wdata", mem_wdata, cur.wdata);
            end
            eic = 1'b0; edc = 1'b0; eerr = 1'b0; eir = 32'h0; edr = 32'h0;
            if (done_q.size() > 0) begin
                d = done_q.pop_front();
                eic  = !d.dc;
                edc  = d.dc;
                eerr = d.err;
                if (d.dc) edr = d.rdata;
                else      eir = d.rdata;
            end
            check("ic_done", ic_done, eic);
            check("dc_done", dc_done, edc);
            check("ic_rdata", ic_rdata, eir);
            check("dc_rdata", dc_rdata, edr);
            check("err", err, eerr);
        end
    end

    // Stimulus.
    initial begin
        logic ic_pend, dc_pend, mem_active;
        int   lat_left;

        rst = 1'b1; ic_req = 1'b0; ic_addr = 32'h0; dc_req = 1'b0; dc_we = 1'b0;
        dc_addr = 32'h0; dc_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();

        // Single icache read, ack two cycles after mem_req.
        ic_req = 1'b1; ic_addr = 32'h100;
        cyc();
        mem_resp(2, 32'hA5A5A5A5);
        ic_req = 1'b0;
        cyc();
        cyc();

        // Contention right after reset: dcache goes first, then alternation.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ic_req = 1'b1; ic_addr = 32'h300;
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h200; dc_wdata = 32'h200;
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_resp(1, 32'h1000 + i);
            cyc();
        end
        ic_req = 1'b0; dc_req = 1'b0;
        mem_resp(0, 32'h2000);
        cyc();
        cyc();

        // Spurious ack while idle.
        mem_ack = 1'b1; mem_rdata = 32'hDEAD0001;
        cyc();
        mem_ack = 1'b0;
        cyc();

        // icache request held high through DONE.
        ic_req = 1'b1; ic_addr = 32'h400;
        cyc();
        mem_resp(0, 32'h4444);
        ic_addr = 32'h404;
        cyc();
        cyc();
        mem_resp(1, 32'h4545);
        ic_req = 1'b0;
        cyc();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD0002;
        cyc();
        mem_ack = 1'b0;
        cyc();

        // Reset in the middle of a dcache read; the late ack must be ignored.
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h500;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; dc_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD0003;
        cyc();
        mem_ack = 1'b0;
        cyc();
        cyc();

        // Long memory stall: 1000 cycles without ack.
        ic_req = 1'b1; ic_addr = 32'h600;
        cyc();
        repeat (1000) cyc();
        mem_resp(0, 32'h6666);
        ic_req = 1'b0;
        cyc();
        cyc();

        // Randomized traffic.
        ic_pend = 1'b0; dc_pend = 1'b0; mem_active = 1'b0; lat_left = 0;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (ph == PH_RESP && !m_owner_dc) ic_pend = 1'b0;
            if (ph == PH_RESP &&  m_owner_dc) dc_pend = 1'b0;
            if (rst) begin
                ic_pend = 1'b0;
                dc_pend = 1'b0;
            end else begin
                if (!ic_pend && $urandom_range(0, 3) == 0) begin
                    ic_pend = 1'b1;
                    ic_addr = $urandom;
                end
                if (!dc_pend && $urandom_range(0, 3) == 0) begin
                    dc_pend  = 1'b1;
                    dc_we    = $urandom_range(0, 1);
                    dc_addr  = $urandom;
                    dc_wdata = $urandom;
                end
            end
            ic_req = ic_pend;
            dc_req = dc_pend;
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            if (ph == PH_MEM) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    lat_left   = $urandom_range(0, 5);
                end
                if (lat_left == 0) mem_ack = 1'b1;
                else lat_left--;
            end else begin
                mem_active = 1'b0;
                mem_ack    = ($urandom_range(0, 7) == 0);
            end
            cyc();
        end

        rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; mem_ack = 1'b0;
        for (int n = 0; n < 300 && ph != PH_FREE; n++) begin
            mem_ack = (ph == PH_MEM);
            cyc();
        end
        mem_ack = 1'b0;
        cyc();
        cyc();
        checks++;
        if (ph != PH_FREE) begin
            errors++;
            $display("FAIL drain: arbiter model still busy, phase %0d required %0d", ph, PH_FREE);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 255, mem_ack wait limit in cycles (range 1..255).
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 ic_req  in  1  icache line-fill read request; held high until ic_done.
REQ-005 ic_addr  in  32  icache read address; stable while ic_req is high.
REQ-006 ic_done  out  1  one-cycle pulse, icache transaction complete.
REQ-007 ic_rdata  out  32  icache read data; valid while ic_done is high.
REQ-008 dc_req  in  1  MSHR request (load fill or dirty eviction); held high until dc_done.
REQ-009 dc_we  in  1  1 = eviction write, 0 = fill read.
REQ-010 dc_addr  in  32  MSHR address; stable while dc_req is high.
REQ-011 dc_wdata  in  32  eviction data.
REQ-012 dc_done  out  1  one-cycle pulse, MSHR transaction complete.
REQ-013 dc_rdata  out  32  fill data; valid while dc_done is high; 0 for writes.
REQ-014 mem_req  out  1  memory request; held high until mem_ack.
REQ-015 mem_we  out  1  memory write enable.
REQ-016 mem_addr  out  32  memory address.
REQ-017 mem_wdata  out  32  memory write data.
REQ-018 mem_ack  in  1  one-cycle memory completion; carries mem_rdata.
REQ-019 mem_rdata  in  32  memory read data; valid with mem_ack.
REQ-020 err  out  1  timeout flag; valid with ic_done/dc_done (Configuration).

Function
REQ-021 FSM states: IDLE, BUSY_IC, BUSY_DC, DONE.
REQ-022 Arbitration is evaluated only in IDLE; requests in any other state are not granted.
REQ-023 IDLE with one request: grant that requester.
REQ-024 IDLE with both requests: grant the requester not in last_gnt (round-robin).
REQ-025 last_gnt updates at every grant.
REQ-026 Grant in IDLE at cycle N: in cycle N+1 the FSM is in BUSY_x and mem_req=1, with mem_addr/mem_we/mem_wdata registered from the granted requester at edge N. mem_we=0 and mem_wdata=0 for icache grants.
REQ-027 In BUSY_x, mem_req and the registered outputs stay constant until mem_ack.
REQ-028 mem_ack in BUSY_x at cycle M: in cycle M+1 the FSM is in DONE, mem_req=0, and the matching done pulses for one cycle with rdata registered from mem_rdata.
REQ-029 DONE always returns to IDLE at the next edge; a still-high req from the served requester is not re-granted while in DONE.
REQ-030 Minimum turnaround is 3 cycles of arbiter overhead plus memory latency; back-to-back grants are at least 3 cycles apart.
REQ-031 mem_ack in IDLE or DONE is ignored and causes no state change.
REQ-032 Outside DONE: ic_done=dc_done=0 and rdata outputs are 0.
REQ-033 ic_done and dc_done are never high in the same cycle.

Reset
REQ-034 On a rst edge, regardless of state: FSM=IDLE, last_gnt=IC (so the first contended grant goes to dcache), all outputs 0, timeout counter 0.
REQ-035 A transaction in flight at reset is abandoned; no done pulse is issued for it; a mem_ack arriving after reset is ignored per REQ-031.

Configuration
REQ-036 Macro ARB_TIMEOUT_EN defined:
- 8-bit counter clears at each grant and increments each BUSY cycle without mem_ack.
- On reaching TIMEOUT_CYC, the FSM enters DONE with done pulsed, rdata=0 and err=1.
- mem_ack in the same cycle as reaching the limit counts as success.
REQ-037 Macro ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; err tied to 0.

Verification
REQ-038 Single read: ic_req, ic_addr=0x100; mem_ack 2 cycles after mem_req with rdata=0xA5A5A5A5 -> mem_req 1 cycle after ic_req, mem_addr=0x100, mem_we=0, ic_done one cycle after mem_ack with ic_rdata=0xA5A5A5A5.
REQ-039 Contention after reset: ic_req and dc_req both high (dc_we=1, dc_addr=0x200, dc_wdata=0x200) -> dcache first (mem_we=1, mem_addr=0x200), dc_rdata=0; icache granted next; grants alternate while both are held.
REQ-040 Spurious and held requests: mem_ack pulsed in IDLE -> no done and no state change; ic_req held high through DONE -> no grant in DONE, regrant no earlier than the cycle after.
REQ-041 Reset mid-BUSY_DC: rst for one edge -> mem_req=0 next cycle, no dc_done, and a subsequent mem_ack is ignored.
REQ-042 ARB_TIMEOUT_EN, TIMEOUT_CYC=4, mem_ack never asserted -> dc_done with err=1 and dc_rdata=0 after 4 BUSY cycles, then FSM returns to IDLE.
REQ-043 ARB_TIMEOUT_EN undefined, mem_ack withheld 1000 cycles -> mem_req held for all 1000 cycles, err stays 0.
